// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator.
// One shared frame counter feeds CHANNELS pulse lanes. Each lane holds a
// commanded target level and an applied level; the applied level walks toward
// the target by at most SLEW_STEP once per frame, at the frame boundary, so a
// pulse width never changes in the middle of a frame.
module servo_pwm_multi #(
   parameter int INPUT_FREQ   = 50_000_000,
   parameter int REFRESH_HZ   = 50,
   parameter int MIN_PULSE_NS = 1_000_000,
   parameter int MAX_PULSE_NS = 2_000_000,
   parameter int CHANNELS     = 4,
   parameter int CH_W         = 4,
   parameter int SLEW_STEP    = 1000,
   parameter int RESET_LEVEL  = 500
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_enable,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [CH_W-1:0]     i_cmd_channel,
   input  logic [9:0]          i_cmd_level,
   output logic                o_cmd_err,
   output logic [CHANNELS-1:0] o_pwm_out,
   output logic                o_frame_start,
   output logic                o_settled
);

   localparam int PERIOD_COUNT = INPUT_FREQ / REFRESH_HZ;
   localparam int MIN_COUNT    = (INPUT_FREQ / 1_000_000) * (MIN_PULSE_NS / 1000);
   localparam int MAX_COUNT    = (INPUT_FREQ / 1_000_000) * (MAX_PULSE_NS / 1000);
   // Counter and pulse-width registers share one width wide enough for both.
   localparam int CNT_SPAN     = (PERIOD_COUNT > MAX_COUNT + 1) ? PERIOD_COUNT : MAX_COUNT + 1;
   localparam int CNT_W        = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;
   localparam logic [9:0] STEP    = (SLEW_STEP >= 1000) ? 10'd1000 : 10'(SLEW_STEP);
   localparam logic [9:0] RST_LVL = 10'(RESET_LEVEL);
   localparam logic [9:0] LVL_MAX = 10'd1000;

   // Level-to-cycles mapping; 32-bit intermediate, truncating divide.
   function automatic logic [CNT_W-1:0] f_count(input logic [9:0] lvl);
      logic [31:0] v;
      v = 32'(MIN_COUNT) + (32'(MAX_COUNT - MIN_COUNT) * {22'd0, lvl}) / 32'd1000;
      return v[CNT_W-1:0];
   endfunction

   logic [CNT_W-1:0]    r_cnt;
   logic                r_frame_start;
   logic                r_cmd_err;
   logic                r_settled;
   logic                w_boundary;
   logic                w_ready;
   logic                w_xfer;
   logic                w_bad_ch;
   logic [9:0]          w_level;
   logic [CHANNELS-1:0] w_eq;
   logic [CHANNELS-1:0] w_pwm;

   // Last cycle of a running frame: the slew update happens at its closing edge.
   assign w_boundary = i_enable & (r_cnt == CNT_W'(PERIOD_COUNT - 1));
   // Target writes are refused in the boundary cycle so they never race the slew step.
   assign w_ready    = i_rst_n & ~w_boundary;
   assign w_xfer     = i_cmd_valid & w_ready;
   assign w_bad_ch   = (32'(i_cmd_channel) >= CHANNELS);
   assign w_level    = (i_cmd_level > LVL_MAX) ? LVL_MAX : i_cmd_level;

   // Shared frame counter; held at zero while disabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (!i_enable || w_boundary)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // Frame marker, registered so it lines up with the first pulse cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_frame_start <= 1'b0;
      else
         r_frame_start <= i_enable & (r_cnt == '0);
   end

   // Error pulse for an accepted command addressed to a channel that does not exist.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cmd_err <= 1'b0;
      else
         r_cmd_err <= w_xfer & w_bad_ch;
   end

   // Settled flag follows the lane compare one cycle later.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_settled <= 1'b1;
      else
         r_settled <= &w_eq;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      logic [9:0]       r_target;
      logic [9:0]       r_applied;
      logic [CNT_W-1:0] r_high;
      logic             r_pwm;
      logic             w_wr;
      logic [9:0]       w_up;
      logic [9:0]       w_dn;
      logic [9:0]       w_next;

      assign w_wr   = w_xfer & ~w_bad_ch & (32'(i_cmd_channel) == g);
      assign w_up   = r_target - r_applied;
      assign w_dn   = r_applied - r_target;
      // Next applied level: one rate-limited step toward the target.
      assign w_next = (r_target > r_applied) ? r_applied + ((w_up > STEP) ? STEP : w_up) :
                      (r_target < r_applied) ? r_applied - ((w_dn > STEP) ? STEP : w_dn) :
                                               r_applied;

      // Commanded target; the last accepted write wins.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)
            r_target <= RST_LVL;
         else if (w_wr)
            r_target <= w_level;
      end

      // Applied level and its pulse width change only at a frame boundary.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_applied <= RST_LVL;
            r_high    <= f_count(RST_LVL);
         end else if (w_boundary) begin
            r_applied <= w_next;
            r_high    <= f_count(w_next);
         end
      end

      // Registered pulse output, one cycle behind the counter.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)
            r_pwm <= 1'b0;
         else
            r_pwm <= i_enable & (r_cnt < r_high);
      end

      assign w_pwm[g] = r_pwm;
      assign w_eq[g]  = (r_target == r_applied);
   end

   assign o_cmd_ready   = w_ready;
   assign o_cmd_err     = r_cmd_err;
   assign o_pwm_out     = w_pwm;
   assign o_frame_start = r_frame_start;
   assign o_settled     = r_settled;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances share one command port, one without
// slew limiting and one limited to 100 levels per frame. A frame-level model
// (targets, applied levels, slew as plain arithmetic) predicts every pulse width.
module tb_servo_pwm_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_channel = 4'd0;
   logic [9:0] cmd_level = 10'd0;
   logic       rdy_f, rdy_s, err_f, err_s, fs_f, fs_s, set_f, set_s;
   logic [3:0] pwm_f, pwm_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   servo_pwm_multi #(.INPUT_FREQ(1_000_000), .REFRESH_HZ(1000), .MIN_PULSE_NS(100_000),
                     .MAX_PULSE_NS(200_000), .CHANNELS(4), .CH_W(4), .SLEW_STEP(1000),
                     .RESET_LEVEL(500)) u_fast (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_cmd_valid(cmd_valid),
      .o_cmd_ready(rdy_f), .i_cmd_channel(cmd_channel), .i_cmd_level(cmd_level),
      .o_cmd_err(err_f), .o_pwm_out(pwm_f), .o_frame_start(fs_f), .o_settled(set_f));

   servo_pwm_multi #(.INPUT_FREQ(1_000_000), .REFRESH_HZ(1000), .MIN_PULSE_NS(100_000),
                     .MAX_PULSE_NS(200_000), .CHANNELS(4), .CH_W(4), .SLEW_STEP(100),
                     .RESET_LEVEL(500)) u_slow (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_cmd_valid(cmd_valid),
      .o_cmd_ready(rdy_s), .i_cmd_channel(cmd_channel), .i_cmd_level(cmd_level),
      .o_cmd_err(err_s), .o_pwm_out(pwm_s), .o_frame_start(fs_s), .o_settled(set_s));

   // ---------------- reference model ----------------
   int m_t;            // enabled cycles since the counter last started from 0
   int m_tgt[2][4];
   int m_app[2][4];
   int last_w[2][4];
   logic last_set[2];

   function automatic int cnt_of(int lvl);
      return 100 + (100 * lvl) / 1000;
   endfunction

   function automatic int step_of(int d);
      return (d == 0) ? 1000 : 100;
   endfunction

   function automatic int slew_delta(int diff, int step);
      if (diff > step) return step;
      if (diff < -step) return -step;
      return diff;
   endfunction

   function automatic bit m_settled(int d);
      for (int c = 0; c < 4; c++)
         if (m_tgt[d][c] != m_app[d][c]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t <= 0;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
               m_tgt[d][c] <= 500;
               m_app[d][c] <= 500;
            end
      end else begin
         if (cmd_valid && !(enable && (m_t % 1000) == 999) && cmd_channel < 4'd4)
            for (int d = 0; d < 2; d++)
               m_tgt[d][cmd_channel[1:0]] <= (cmd_level > 10'd1000) ? 1000 : int'(cmd_level);
         if (enable) begin
            if ((m_t % 1000) == 999)
               for (int d = 0; d < 2; d++)
                  for (int c = 0; c < 4; c++)
                     m_app[d][c] <= m_app[d][c] + slew_delta(m_tgt[d][c] - m_app[d][c], step_of(d));
            m_t <= m_t + 1;
         end else begin
            m_t <= 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input int ch, input int lvl);
      if (enable && (m_t % 1000) == 999) @(negedge clk);
      cmd_channel = 4'(ch);
      cmd_level   = 10'(lvl);
      cmd_valid   = 1'b1;
      @(negedge clk);
      cmd_valid   = 1'b0;
   endtask

   // Waits for the next frame_start, then samples one whole frame on both instances.
   task automatic measure_frame(output int waited);
      int  exp_w[2][4];
      int  hi[2][4];
      bit  bad[2][4];
      int  extra;
      logic [3:0] pw;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (fs_f !== 1'b1 && waited < 2100);
      n_checks++;
      if (fs_f !== 1'b1 || fs_s !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_start_seen: fast=%b slow=%b after %0d cycles, required 1", fs_f, fs_s, waited);
         return;
      end
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            exp_w[d][c] = cnt_of(m_app[d][c]);
            hi[d][c]    = 0;
            bad[d][c]   = 1'b0;
         end
      extra = 0;
      for (int idx = 0; idx < 1000; idx++) begin
         if (idx > 0) begin
            @(negedge clk);
            if (fs_f !== 1'b0 || fs_s !== 1'b0) extra++;
         end
         for (int d = 0; d < 2; d++) begin
            pw = (d == 0) ? pwm_f : pwm_s;
            for (int c = 0; c < 4; c++) begin
               if (pw[c] === 1'b1) hi[d][c]++;
               if (pw[c] !== ((idx < exp_w[d][c]) ? 1'b1 : 1'b0)) bad[d][c] = 1'b1;
            end
         end
         if (idx == 500) begin
            last_set[0] = set_f;
            last_set[1] = set_s;
            n_checks++;
            if (set_f !== m_settled(0) || set_s !== m_settled(1)) begin
               n_fail++;
               $display("FAIL settled_mid_frame: got fast=%b slow=%b, expected fast=%b slow=%b",
                        set_f, set_s, m_settled(0), m_settled(1));
            end
         end
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL frame_start_width: %0d extra frame_start cycles in frame, expected 0", extra);
      end
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            last_w[d][c] = hi[d][c];
            n_checks++;
            if (hi[d][c] != exp_w[d][c] || bad[d][c]) begin
               n_fail++;
               $display("FAIL pulse_width dut%0d ch%0d: got %0d cycles (shape_err=%0d), expected %0d starting at frame_start",
                        d, c, hi[d][c], bad[d][c], exp_w[d][c]);
            end
         end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (pwm_f !== 4'h0 || pwm_s !== 4'h0) begin
         n_fail++; $display("FAIL reset_pwm: got %h/%h, expected 0/0", pwm_f, pwm_s);
      end
      n_checks++;
      if (fs_f !== 1'b0 || fs_s !== 1'b0) begin
         n_fail++; $display("FAIL reset_frame_start: got %b/%b, expected 0/0", fs_f, fs_s);
      end
      n_checks++;
      if (err_f !== 1'b0 || err_s !== 1'b0) begin
         n_fail++; $display("FAIL reset_cmd_err: got %b/%b, expected 0/0", err_f, err_s);
      end
      n_checks++;
      if (set_f !== 1'b1 || set_s !== 1'b1) begin
         n_fail++; $display("FAIL reset_settled: got %b/%b, expected 1/1", set_f, set_s);
      end
      n_checks++;
      if (rdy_f !== 1'b0 || rdy_s !== 1'b0) begin
         n_fail++; $display("FAIL reset_cmd_ready: got %b/%b, expected 0/0", rdy_f, rdy_s);
      end
      rst_n  = 1'b1;
      enable = 1'b1;
   endtask

   task automatic test_power_on_frames();
      int w;
      for (int f = 0; f < 2; f++) begin
         measure_frame(w);
         n_checks++;
         if (w != 1) begin
            n_fail++; $display("FAIL frame_period frame%0d: frame_start after %0d cycles, expected 1", f, w);
         end
      end
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (last_w[d][c] != 150) begin
               n_fail++; $display("FAIL power_on_width dut%0d ch%0d: got %0d, expected 150", d, c, last_w[d][c]);
            end
         end
      n_checks++;
      if (last_set[0] !== 1'b1 || last_set[1] !== 1'b1) begin
         n_fail++; $display("FAIL power_on_settled: got %b/%b, expected 1/1", last_set[0], last_set[1]);
      end
   endtask

   task automatic test_single_write();
      int w;
      fork
         measure_frame(w);
         begin
            repeat (300) @(negedge clk);
            send_cmd(2, 1000);
         end
      join
      n_checks++;
      if (last_w[0][2] != 150) begin
         n_fail++; $display("FAIL write_same_frame: got %0d, expected 150", last_w[0][2]);
      end
      measure_frame(w);
      n_checks++;
      if (last_w[0][2] != 200 || last_w[0][0] != 150 || last_w[0][1] != 150 || last_w[0][3] != 150) begin
         n_fail++;
         $display("FAIL write_next_frame: got %0d/%0d/%0d/%0d, expected 150/150/200/150",
                  last_w[0][0], last_w[0][1], last_w[0][2], last_w[0][3]);
      end
   endtask

   task automatic test_slew();
      int w;
      for (int i = 0; i < 12 && !(m_settled(0) && m_settled(1)); i++) measure_frame(w);
      send_cmd(0, 1000);
      for (int k = 0; k < 5; k++) begin
         measure_frame(w);
         n_checks++;
         if (last_w[1][0] != 160 + 10 * k) begin
            n_fail++; $display("FAIL slew_width frame%0d: got %0d, expected %0d", k, last_w[1][0], 160 + 10 * k);
         end
         n_checks++;
         if (last_set[1] !== ((k == 4) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL slew_settled frame%0d: got %b, expected %b", k, last_set[1], (k == 4));
         end
         if (k == 0) begin
            n_checks++;
            if (last_w[0][0] != 200) begin
               n_fail++; $display("FAIL unlimited_jump: got %0d, expected 200", last_w[0][0]);
            end
         end
      end
   endtask

   task automatic test_clamp_and_bad_channel();
      int w;
      int prev[2][4];
      send_cmd(1, 1023);
      measure_frame(w);
      n_checks++;
      if (last_w[0][1] != 200 || last_w[1][1] != 160) begin
         n_fail++; $display("FAIL clamp_first_frame: got %0d/%0d, expected 200/160", last_w[0][1], last_w[1][1]);
      end
      for (int i = 0; i < 12 && !(m_settled(0) && m_settled(1)); i++) measure_frame(w);
      measure_frame(w);
      n_checks++;
      if (last_w[1][1] != 200) begin
         n_fail++; $display("FAIL clamp_settled_width: got %0d, expected 200", last_w[1][1]);
      end
      prev = last_w;
      send_cmd(7, 0);
      n_checks++;
      if (err_f !== 1'b1 || err_s !== 1'b1) begin
         n_fail++; $display("FAIL bad_channel_err: got %b/%b, expected 1/1", err_f, err_s);
      end
      @(negedge clk);
      n_checks++;
      if (err_f !== 1'b0 || err_s !== 1'b0) begin
         n_fail++; $display("FAIL bad_channel_err_width: got %b/%b, expected 0/0", err_f, err_s);
      end
      measure_frame(w);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (last_w[d][c] != prev[d][c]) begin
               n_fail++; $display("FAIL bad_channel_no_change dut%0d ch%0d: got %0d, expected %0d",
                                  d, c, last_w[d][c], prev[d][c]);
            end
         end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int lvl;
      int w;
      while (!(enable && (m_t % 1000) == 998) && n < 1100) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 1100) begin
         n_fail++; $display("FAIL boundary_search: boundary not reached in %0d cycles, expected < 1100", n);
      end
      n_checks++;
      if (rdy_f !== 1'b1 || rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL ready_before_boundary: got %b/%b, expected 1/1", rdy_f, rdy_s);
      end
      @(negedge clk);
      lvl = $urandom_range(0, 1000);
      if (lvl == m_tgt[0][3]) lvl = (lvl + 1) % 1001;
      cmd_channel = 4'd3;
      cmd_level   = 10'(lvl);
      cmd_valid   = 1'b1;
      n_checks++;
      if (rdy_f !== 1'b0 || rdy_s !== 1'b0) begin
         n_fail++; $display("FAIL ready_in_boundary: got %b/%b, expected 0/0", rdy_f, rdy_s);
      end
      @(negedge clk);
      n_checks++;
      if (rdy_f !== 1'b1 || rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_boundary: got %b/%b, expected 1/1", rdy_f, rdy_s);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (set_f !== 1'b0) begin
         n_fail++; $display("FAIL held_cmd_transfer: settled got %b, expected 0 after target change", set_f);
      end
      measure_frame(w);
      n_checks++;
      if (last_w[0][3] != cnt_of(lvl)) begin
         n_fail++; $display("FAIL held_cmd_width: got %0d, expected %0d for level %0d", last_w[0][3], cnt_of(lvl), lvl);
      end
   endtask

   task automatic test_random();
      int w;
      int ch;
      int lvl;
      for (int it = 0; it < 4; it++) begin
         repeat ($urandom_range(0, 1500)) @(negedge clk);
         ch  = $urandom_range(0, 7);
         lvl = $urandom_range(0, 1023);
         send_cmd(ch, lvl);
         n_checks++;
         if (err_f !== (ch >= 4) || err_s !== (ch >= 4)) begin
            n_fail++; $display("FAIL random_cmd_err ch%0d: got %b/%b, expected %b", ch, err_f, err_s, (ch >= 4));
         end
         measure_frame(w);
         measure_frame(w);
      end
   endtask

   task automatic test_enable_and_reset();
      int w;
      int stray = 0;
      measure_frame(w);
      repeat (50) @(negedge clk);
      n_checks++;
      if (pwm_f !== 4'hF || pwm_s !== 4'hF) begin
         n_fail++; $display("FAIL pulse_high_at_50: got %h/%h, expected f/f", pwm_f, pwm_s);
      end
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pwm_f !== 4'h0 || pwm_s !== 4'h0) begin
         n_fail++; $display("FAIL disable_pwm: got %h/%h, expected 0/0", pwm_f, pwm_s);
      end
      repeat (20) begin
         @(negedge clk);
         if (pwm_f !== 4'h0 || pwm_s !== 4'h0 || fs_f !== 1'b0 || fs_s !== 1'b0) stray++;
      end
      n_checks++;
      if (stray != 0) begin
         n_fail++; $display("FAIL disabled_quiet: %0d active cycles, expected 0", stray);
      end
      n_checks++;
      if (rdy_f !== 1'b1 || rdy_s !== 1'b1) begin
         n_fail++; $display("FAIL disabled_ready: got %b/%b, expected 1/1", rdy_f, rdy_s);
      end
      send_cmd(3, $urandom_range(0, 1000));
      enable = 1'b1;
      measure_frame(w);
      n_checks++;
      if (w != 1) begin
         n_fail++; $display("FAIL reenable_frame_start: after %0d cycles, expected 1", w);
      end
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (pwm_f !== 4'h0 || pwm_s !== 4'h0 || set_f !== 1'b1 || set_s !== 1'b1 || rdy_f !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: pwm %h/%h settled %b/%b ready %b, expected 0/0 1/1 0",
                            pwm_f, pwm_s, set_f, set_s, rdy_f);
      end
      @(negedge clk);
      rst_n = 1'b1;
      measure_frame(w);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (last_w[d][c] != 150) begin
               n_fail++; $display("FAIL post_reset_width dut%0d ch%0d: got %0d, expected 150", d, c, last_w[d][c]);
            end
         end
   endtask

   initial begin
      test_reset();
      test_power_on_frames();
      test_single_write();
      test_slew();
      test_clamp_and_bad_channel();
      test_back_to_back();
      test_random();
      test_enable_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
